univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register with a built-in parallel-to-serial sequencer, generalising the team's 4-bit PIPO register. Supports hold, shift-right, shift-left and parallel-load modes at any width, plus a start-triggered auto-serialize sequence (MSB-first) with busy/done status. It sits between parallel datapath registers and serial links or bit-level test logic.

## Interface
- WIDTH, 8, register width in bits (≥2)
- RST_VAL, {WIDTH{1'b0}}, register contents after reset
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  clock enable; 0 freezes register, counter and FSM
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load (IDLE only)
- p_in  in  WIDTH  parallel load data
- ser_in_msb  in  1  bit entering MSB on shift right
- ser_in_lsb  in  1  bit entering LSB on shift left and auto-serialize
- start  in  1  begin auto-serialize of p_in (IDLE only)
- p_out  out  WIDTH  register contents
- ser_out_msb  out  1  p_out[WIDTH-1]
- ser_out_lsb  out  1  p_out[0]
- busy  out  1  high while in SHIFT
- done  out  1  one-cycle pulse at end of auto-serialize
- parity  out  1  only with UNIV_SR_PARITY_EN

## Operation
- FSM states: IDLE, SHIFT. Reset → IDLE.
- IDLE, en=1, start=0: mode applied to register:
  - 00: sr unchanged
  - 01: sr ← {ser_in_msb, sr[WIDTH-1:1]}
  - 10: sr ← {sr[WIDTH-2:0], ser_in_lsb}
  - 11: sr ← p_in
- IDLE, en=1, start=1: start wins over mode; sr ← p_in, cnt ← 0, → SHIFT.
- SHIFT, en=1: sr ← {sr[WIDTH-2:0], ser_in_lsb}, cnt ← cnt+1; at the edge where cnt==WIDTH-1, → IDLE and done ← 1.
- SHIFT: mode and start ignored.
- en=0: sr, cnt, state held; done still deasserts after one cycle.
- cnt width $clog2(WIDTH); internal only.
- ser_out_msb/ser_out_lsb/p_out combinational from sr.

## Timing
- Reset (rst high at edge): sr=RST_VAL, state IDLE, cnt=0, busy=0, done=0; rst overrides en and all inputs, including mid-SHIFT (sequence aborted, no done).
- Mode ops and parallel load: one-cycle latency, result visible on p_out after the edge.
- Auto-serialize: start sampled at edge T0; during cycle k (k=0..WIDTH-1, with en held high) after T0, ser_out_msb = p_in[WIDTH-1-k]. busy high from T0 to edge T0+WIDTH; done high for the single cycle after edge T0+WIDTH. Stalls via en=0 extend the sequence one cycle each.
- busy is registered from state; next start accepted the cycle done is high (back-to-back, no gap).
- After sequence, sr contains the WIDTH bits shifted in on ser_in_lsb.

## Configuration
- UNIV_SR_PARITY_EN defined: parity output present, parity = ^sr (even parity of p_out, combinational); reset value ^RST_VAL.
- Undefined: parity port and logic omitted; all other behaviour identical.

## Test plan
- WIDTH=4: rst=1 one cycle → p_out=0000, busy=0, done=0; then mode=11, p_in=1100 → p_out=1100 next cycle; mode=00 → holds 1100.
- p_out=1100, mode=01, ser_in_msb=1 → 1110, then 1111; mode=10, ser_in_lsb=0 → 1110, then 1100.
- start with p_in=1011, ser_in_lsb=0 → ser_out_msb 1,0,1,1 over 4 cycles, busy 4 cycles, done one pulse, final p_out=0000.
- Auto-serialize p_in=1011 with en=0 for 2 cycles mid-sequence → same bit order, busy 6 cycles, done once; start/mode=11 during busy ignored.
- rst asserted in 2nd SHIFT cycle → p_out=0000, busy=0, no done pulse; new start afterwards runs normally.
- With UNIV_SR_PARITY_EN, WIDTH=8: load 10110000 → parity=1; load 10110001 → parity=0.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register (hold, shift right,
// shift left, parallel load) with an MSB-first auto-serialize sequencer.
// The serializer reports its progress on busy and done.
// Optional macro UNIV_SR_PARITY_EN adds a combinational even-parity output.
// Reset is synchronous and active-high.
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] p_in,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  input  logic             start,
  output logic [WIDTH-1:0] p_out,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             busy,
  output logic             done
`ifdef UNIV_SR_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next-state logic: start outranks mode in IDLE; SHIFT always shifts left
  // until WIDTH bits have gone out. done is a one-cycle pulse, even when en is low.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_d    = p_in;
            cnt_d   = '0;
            state_d = SHIFT;
          end else begin
            case (mode)
              2'b00:   sr_d = sr_q;
              2'b01:   sr_d = {ser_in_msb, sr_q[WIDTH-1:1]};
              2'b10:   sr_d = {sr_q[WIDTH-2:0], ser_in_lsb};
              default: sr_d = p_in;
            endcase
          end
        end
        SHIFT: begin
          sr_d  = {sr_q[WIDTH-2:0], ser_in_lsb};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; reset aborts any running sequence without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= RST_VAL;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign p_out       = sr_q;
  assign ser_out_msb = sr_q[WIDTH-1];
  assign ser_out_lsb = sr_q[0];
  assign busy        = (state_q == SHIFT);
  assign done        = done_q;

`ifdef UNIV_SR_PARITY_EN
  assign parity = ^sr_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: scoreboard bench for univ_shift_reg (WIDTH=4).
// The driver updates a behavioural model and queues the expected results.
// An independent monitor pops the queued expectations and compares them with the DUT.
module tb_univ_shift_reg;

  localparam int          W  = 4;
  localparam logic [W-1:0] RV = '0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         start = 1'b0;
  logic         ser_in_msb = 1'b0;
  logic         ser_in_lsb = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] p_in = '0;
  logic [W-1:0] p_out;
  logic         ser_out_msb, ser_out_lsb, busy, done;
`ifdef UNIV_SR_PARITY_EN
  logic         parity;
`endif

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W), .RST_VAL(RV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .p_in       (p_in),
    .ser_in_msb (ser_in_msb),
    .ser_in_lsb (ser_in_lsb),
    .start      (start),
    .p_out      (p_out),
    .ser_out_msb(ser_out_msb),
    .ser_out_lsb(ser_out_lsb),
    .busy       (busy),
    .done       (done)
`ifdef UNIV_SR_PARITY_EN
    ,
    .parity     (parity)
`endif
  );

  typedef struct packed {
    logic [W-1:0] p;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t         expQ[$];
  logic         bitQ[$];
  int           checks = 0;
  int           failures = 0;

  logic [W-1:0] modelSr = RV;
  int           bitsLeft = 0;
  logic         modelDone = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model and queue the expected outcome.
  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                               input logic [W-1:0] d, input logic msb, input logic lsb,
                               input logic s);
    @(negedge clk);
    rst = r; en = e; mode = m; p_in = d; ser_in_msb = msb; ser_in_lsb = lsb; start = s;
    modelDone = 1'b0;
    if (r) begin
      modelSr  = RV;
      bitsLeft = 0;
    end else if (e) begin
      if (bitsLeft > 0) begin
        modelSr = (modelSr << 1) | W'(lsb);
        bitsLeft--;
        if (bitsLeft == 0) modelDone = 1'b1;
      end else if (s) begin
        modelSr  = d;
        bitsLeft = W;
        for (int i = W - 1; i >= 0; i--) bitQ.push_back(d[i]);
      end else begin
        case (m)
          2'd1:    modelSr = (modelSr >> 1) | (W'(msb) << (W - 1));
          2'd2:    modelSr = (modelSr << 1) | W'(lsb);
          2'd3:    modelSr = d;
          default: modelSr = modelSr;
        endcase
      end
    end
    expQ.push_back('{p: modelSr, busy: (bitsLeft > 0), done: modelDone});
  endtask

  // Monitor: after each edge, compare the DUT with the next queued expectation.
  // Also track the MSB-first bit stream of the serializer.
  initial begin
    exp_t e;
    logic prevExpBusy;
    prevExpBusy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bitQ.delete();
      end else if (prevExpBusy && en) begin
        if (bitQ.size() > 0) void'(bitQ.pop_front());
        else checkOutput("serial_underflow", 32'd1, 32'd0);
      end
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("p_out", 32'(p_out), 32'(e.p));
        checkOutput("busy", 32'(busy), 32'(e.busy));
        checkOutput("done", 32'(done), 32'(e.done));
        checkOutput("ser_out_lsb", 32'(ser_out_lsb), 32'(e.p[0]));
`ifdef UNIV_SR_PARITY_EN
        checkOutput("parity", 32'(parity), 32'(^e.p));
`endif
        if (e.busy) begin
          if (bitQ.size() == 0) checkOutput("serial_bit_missing", 32'd1, 32'd0);
          else checkOutput("serial_bit", 32'(ser_out_msb), 32'(bitQ[0]));
        end
        if (e.done) checkOutput("serial_all_sent", 32'(bitQ.size()), 32'd0);
        prevExpBusy = e.busy;
      end
    end
  end

  initial begin
    // Reset, load, and hold
    applyStimulus(1, 1, 2'd0, 4'b0000, 0, 0, 0);
    applyStimulus(0, 1, 2'd3, 4'b1100, 0, 0, 0);
    applyStimulus(0, 1, 2'd0, 4'b0000, 0, 0, 0);
    // Shift right twice, then shift left twice
    applyStimulus(0, 1, 2'd1, 4'b0000, 1, 0, 0);
    applyStimulus(0, 1, 2'd1, 4'b0000, 1, 0, 0);
    applyStimulus(0, 1, 2'd2, 4'b0000, 0, 0, 0);
    applyStimulus(0, 1, 2'd2, 4'b0000, 0, 0, 0);
    // Plain auto-serialize of 1011
    applyStimulus(0, 1, 2'd0, 4'b1011, 0, 0, 1);
    repeat (4) applyStimulus(0, 1, 2'd0, 4'b0000, 0, 0, 0);
    // Auto-serialize with a two-cycle stall; start and load attempts while busy are ignored
    applyStimulus(0, 1, 2'd0, 4'b1011, 0, 0, 1);
    applyStimulus(0, 1, 2'd3, 4'b0110, 0, 0, 1);
    applyStimulus(0, 0, 2'd3, 4'b0110, 0, 1, 1);
    applyStimulus(0, 0, 2'd0, 4'b0000, 0, 1, 0);
    applyStimulus(0, 1, 2'd3, 4'b0101, 0, 1, 1);
    applyStimulus(0, 1, 2'd0, 4'b0000, 0, 0, 0);
    applyStimulus(0, 1, 2'd0, 4'b0000, 0, 0, 0);
    // Reset during the second SHIFT cycle, then a clean run
    applyStimulus(0, 1, 2'd0, 4'b1011, 0, 0, 1);
    applyStimulus(0, 1, 2'd0, 4'b0000, 0, 1, 0);
    applyStimulus(1, 1, 2'd0, 4'b0000, 0, 1, 0);
    applyStimulus(0, 1, 2'd0, 4'b0110, 0, 1, 1);
    repeat (4) applyStimulus(0, 1, 2'd0, 4'b0000, 0, 1, 0);
    // Back-to-back sequences: the next start lands on the done cycle
    applyStimulus(0, 1, 2'd0, 4'b1001, 0, 0, 1);
    repeat (3) applyStimulus(0, 1, 2'd0, 4'b0000, 0, 1, 0);
    applyStimulus(0, 1, 2'd0, 4'b0111, 0, 0, 1);
    applyStimulus(0, 1, 2'd0, 4'b0000, 0, 1, 0);
    repeat (4) applyStimulus(0, 1, 2'd0, 4'b0000, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
                    2'($urandom_range(0, 3)), W'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 5) == 0));
    end
    applyStimulus(0, 1, 2'd0, 4'b0000, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
